// File: rtl/ch_stage_sequencer.sv
// Cluster-head stage sequencer: launches each processing stage in order and grants it the shared memory port.
// Optional per-stage watchdog enabled by defining SEQ_TIMEOUT_EN.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | no run; waits for en
//   S_LAUNCH | one-cycle start pulse to stage idx, watchdog cleared
//   S_WAIT   | stage idx owns the memory port until its done
//   S_NEXT   | bus turnaround, advance idx or finish
//   S_FINISH | one-cycle done pulse to the node controller
module ch_stage_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int ADDR_W         = 11,
    parameter int WORD_W         = 16,
    parameter int TIMEOUT_CYCLES = 4095,
    localparam int IDX_W         = $clog2(NUM_STAGES)
) (
    input  logic                         clock,
    input  logic                         nrst,
    input  logic                         en,
    input  logic                         abort,
    output logic [NUM_STAGES-1:0]        stage_start,
    input  logic [NUM_STAGES-1:0]        stage_done,
    input  logic [NUM_STAGES*ADDR_W-1:0] stage_address,
    input  logic [NUM_STAGES-1:0]        stage_wr_en,
    input  logic [NUM_STAGES*WORD_W-1:0] stage_data_out,
    output logic [ADDR_W-1:0]            address,
    output logic                         wr_en,
    output logic [WORD_W-1:0]            data_out,
    output logic                         busy,
    output logic [IDX_W-1:0]             active_stage,
    output logic                         done,
    output logic                         error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    if (NUM_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ch_stage_sequencer: NUM_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic              grant_done;
    logic              grant_wr;
    logic [ADDR_W-1:0] grant_addr;
    logic [WORD_W-1:0] grant_data;

`ifdef SEQ_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;
`endif

    // Select the signals of the stage addressed by the registered index only.
    always_comb begin
        grant_done = 1'b0;
        grant_wr   = 1'b0;
        grant_addr = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                grant_done = stage_done[i];
                grant_wr   = stage_wr_en[i];
                grant_addr = stage_address[i*ADDR_W +: ADDR_W];
                grant_data = stage_data_out[i*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
`ifdef SEQ_TIMEOUT_EN
        wd_d    = wd_q;
        error_d = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    idx_d   = '0;
                    state_d = S_LAUNCH;
`ifdef SEQ_TIMEOUT_EN
                    error_d = 1'b0;
`endif
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            S_WAIT: begin
                if (grant_done) begin
                    state_d = S_NEXT;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort beats both a coincident stage done and a watchdog expiry.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
`ifdef SEQ_TIMEOUT_EN
            error_d = error_q;
`endif
        end
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_comb begin
        stage_start = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_start[i] = (state_q == S_LAUNCH) && (idx_q == IDX_W'(i));
        end
    end

    // Memory port is driven only while a stage is granted; all other states park it at zero.
    always_comb begin
        address  = '0;
        data_out = '0;
        wr_en    = 1'b0;
        if (state_q == S_WAIT) begin
            address  = grant_addr;
            data_out = grant_data;
            wr_en    = grant_wr & ~abort;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FINISH);
    assign active_stage = idx_q;

endmodule

// File: tb/tb_ch_stage_sequencer.sv
// Directed bench for ch_stage_sequencer: cycle table for full and aborted runs, plus hand-written corner sequences.
module tb_ch_stage_sequencer;

    localparam int NS = 4;
    localparam int AW = 11;
    localparam int WW = 16;

    logic           clock = 1'b0;
    logic           nrst  = 1'b0;
    logic           en    = 1'b0;
    logic           abort = 1'b0;
    logic [NS-1:0]    stage_start;
    logic [NS-1:0]    stage_done;
    logic [NS*AW-1:0] stage_address;
    logic [NS-1:0]    stage_wr_en;
    logic [NS*WW-1:0] stage_data_out;
    logic [AW-1:0]  address;
    logic           wr_en;
    logic [WW-1:0]  data_out;
    logic           busy;
    logic [1:0]     active_stage;
    logic           done;
    logic           error;

    logic [NS-1:0]  auto_m   = 4'hF;
    logic [NS-1:0]  frc      = 4'h0;
    logic [NS-1:0]  done_auto;

    int n_checks = 0;
    int n_errors = 0;

    ch_stage_sequencer #(
        .NUM_STAGES    (NS),
        .ADDR_W        (AW),
        .WORD_W        (WW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock         (clock),
        .nrst          (nrst),
        .en            (en),
        .abort         (abort),
        .stage_start   (stage_start),
        .stage_done    (stage_done),
        .stage_address (stage_address),
        .stage_wr_en   (stage_wr_en),
        .stage_data_out(stage_data_out),
        .address       (address),
        .wr_en         (wr_en),
        .data_out      (data_out),
        .busy          (busy),
        .active_stage  (active_stage),
        .done          (done),
        .error         (error)
    );

    always #5 clock = ~clock;

    // Stage model: registered done one cycle after start, for stages enabled in auto_m.
    always @(posedge clock or negedge nrst) begin
        if (!nrst) done_auto <= '0;
        else       done_auto <= stage_start & auto_m;
    end
    assign stage_done = done_auto | frc;

    typedef struct {
        logic        e;
        logic        a;
        logic [3:0]  am;
        logic [3:0]  fr;
        logic [3:0]  st;
        logic        b;
        logic        d;
        logic [1:0]  act;
        logic [10:0] ad;
        logic        w;
        logic [15:0] dt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic e, input logic a, input logic [3:0] am, input logic [3:0] fr,
                                input logic [3:0] st, input logic b, input logic d, input logic [1:0] act,
                                input logic [10:0] ad, input logic w, input logic [15:0] dt);
        vec_t v;
        v.e = e; v.a = a; v.am = am; v.fr = fr; v.st = st; v.b = b; v.d = d;
        v.act = act; v.ad = ad; v.w = w; v.dt = dt;
        return v;
    endfunction

    function automatic logic [63:0] obs();
        return 64'({stage_start, busy, done, active_stage, address, wr_en, data_out});
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Advance until stage s is in WAIT (port shows its address); returns 0 if the budget runs out.
    task automatic reach_wait(input logic [1:0] s, input logic [10:0] s_addr, output logic found);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (busy && active_stage == s && address == s_addr) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout simulation ran past its time budget");
        $fatal(1);
    end

    initial begin
        logic found;
        logic done_seen;
        int   wait_cnt;

        stage_address  = {11'h7FF, 11'h3A5, 11'h274, 11'h011};
        stage_data_out = {16'hFFFF, 16'hC0DE, 16'hBEEF, 16'h1111};
        stage_wr_en    = 4'b1110;

        //      e  a  am    fr    st    b  d  act ad       w  dt
        // run 1: all stages complete after one WAIT cycle
        tbl.push_back(mk(1, 0, 4'hF, 4'h0, 4'h0, 0, 0, 0, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h1, 1, 0, 0, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 1, 0, 0, 11'h011, 0, 16'h1111));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 1, 0, 0, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h2, 1, 0, 1, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 1, 0, 1, 11'h274, 1, 16'hBEEF));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 1, 0, 1, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h4, 1, 0, 2, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 1, 0, 2, 11'h3A5, 1, 16'hC0DE));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 1, 0, 2, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h8, 1, 0, 3, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 1, 0, 3, 11'h7FF, 1, 16'hFFFF));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 1, 0, 3, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 1, 1, 3, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 0, 0, 3, 11'h000, 0, 16'h0000));
        // run 2: abort in IDLE ignored, stray done on stage 3, stage 1 slow, abort in stage 2 WAIT
        tbl.push_back(mk(1, 1, 4'hF, 4'h0, 4'h0, 0, 0, 3, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h1, 1, 0, 0, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 1, 0, 0, 11'h011, 0, 16'h1111));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 1, 0, 0, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hD, 4'h0, 4'h2, 1, 0, 1, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hD, 4'h8, 4'h0, 1, 0, 1, 11'h274, 1, 16'hBEEF));
        tbl.push_back(mk(0, 0, 4'hD, 4'h8, 4'h0, 1, 0, 1, 11'h274, 1, 16'hBEEF));
        tbl.push_back(mk(0, 0, 4'hD, 4'h2, 4'h0, 1, 0, 1, 11'h274, 1, 16'hBEEF));
        tbl.push_back(mk(0, 0, 4'hD, 4'h0, 4'h0, 1, 0, 1, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hB, 4'h0, 4'h4, 1, 0, 2, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 1, 4'hB, 4'h0, 4'h0, 1, 0, 2, 11'h3A5, 0, 16'hC0DE));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 0, 0, 2, 11'h000, 0, 16'h0000));
        tbl.push_back(mk(0, 0, 4'hF, 4'h0, 4'h0, 0, 0, 2, 11'h000, 0, 16'h0000));

        // Reset state
        #3;
        check("reset_outputs", obs(), 64'h0);
        check("reset_error", 64'(error), 64'h0);
        @(negedge clock);
        nrst = 1'b1;
        @(negedge clock);

        for (int r = 0; r < tbl.size(); r++) begin
            en     = tbl[r].e;
            abort  = tbl[r].a;
            auto_m = tbl[r].am;
            frc    = tbl[r].fr;
            #1;
            check($sformatf("table_row_%0d", r), obs(),
                  64'({tbl[r].st, tbl[r].b, tbl[r].d, tbl[r].act, tbl[r].ad, tbl[r].w, tbl[r].dt}));
            step();
        end
        en = 1'b0; abort = 1'b0; auto_m = 4'hF; frc = 4'h0;

        // Abort coincident with stage 2 done
        en = 1'b1;
        step();
        en = 1'b0;
        reach_wait(2'd2, 11'h3A5, found);
        check("abort_done_reach_wait2", 64'(found), 64'h1);
        check("abort_done_stage_done_seen", 64'(stage_done[2]), 64'h1);
        abort = 1'b1;
        #1;
        check("abort_done_wr_en_same_cycle", 64'(wr_en), 64'h0);
        step();
        abort = 1'b0;
        #1;
        check("abort_done_idle_next", 64'(busy), 64'h0);
        done_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            done_seen |= done;
            step();
        end
        check("abort_done_no_done_pulse", 64'(done_seen), 64'h0);

        // Asynchronous reset in the middle of stage 2 WAIT
        auto_m = 4'hB;
        en = 1'b1;
        step();
        en = 1'b0;
        reach_wait(2'd2, 11'h3A5, found);
        check("reset_mid_reach_wait2", 64'(found), 64'h1);
        #2;
        nrst = 1'b0;
        #1;
        check("reset_mid_outputs_async", obs(), 64'h0);
        check("reset_mid_error", 64'(error), 64'h0);
        @(negedge clock);
        nrst = 1'b1;
        step();
        check("reset_mid_idle_after_release", obs(), 64'h0);

        // Fresh run after reset starts at stage 0; stage 1 then never completes
        auto_m = 4'hD;
        en = 1'b1;
        step();
        en = 1'b0;
        check("rerun_start_stage0", 64'({stage_start, active_stage}), 64'({4'h1, 2'd0}));
        wait_cnt  = 0;
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            done_seen |= done;
            if (!busy) break;
            if (active_stage == 2'd1 && address == 11'h274) wait_cnt++;
        end
`ifdef SEQ_TIMEOUT_EN
        check("timeout_wait_cycles", 64'(wait_cnt), 64'd16);
        check("timeout_idle", 64'(busy), 64'h0);
        check("timeout_error_set", 64'(error), 64'h1);
        check("timeout_no_done", 64'(done_seen), 64'h0);
        step();
        check("timeout_error_sticky", 64'(error), 64'h1);
        auto_m = 4'hF;
        en = 1'b1;
        step();
        en = 1'b0;
        check("timeout_error_cleared_by_en", 64'(error), 64'h0);
`else
        check("stall_still_busy", 64'(busy), 64'h1);
        check("stall_waits_past_limit", 64'(wait_cnt > 16), 64'h1);
        check("stall_error_tied_low", 64'(error), 64'h0);
        check("stall_no_done", 64'(done_seen), 64'h0);
`endif
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        check("final_abort_idle", 64'(busy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ch_stage_sequencer.md
# ch_stage_sequencer

Top-level sequencer for the cluster-head processing chain: launches each processing stage (CH-list fixup, best-hop search, Q-value update, ...) in order with a one-cycle start pulse and waits for its done. It owns the single shared data-memory port (2048 × 8, 16-bit words, 11-bit byte address) and grants it to exactly one stage at a time. It sits between the node controller (`en`/`done`) and the stage modules.

## Interface
Parameters:
- `NUM_STAGES`, 4: number of sequenced stages, minimum 2.
- `ADDR_W`, 11: memory address width.
- `WORD_W`, 16: memory data width.
- `TIMEOUT_CYCLES`, 4095: watchdog limit per stage; only used with `SEQ_TIMEOUT_EN`.

Ports:
- `clock`  in  1  single clock, rising edge.
- `nrst`  in  1  reset, asynchronous and active-low.
- `en`  in  1  run request, sampled in IDLE.
- `abort`  in  1  cancel the run in progress.
- `stage_start`  out  NUM_STAGES  one-hot, one-cycle start pulse per stage.
- `stage_done`  in  NUM_STAGES  per-stage completion.
- `stage_address`  in  NUM_STAGES*ADDR_W  packed stage addresses, stage 0 in the LSBs.
- `stage_wr_en`  in  NUM_STAGES  per-stage write enables.
- `stage_data_out`  in  NUM_STAGES*WORD_W  packed per-stage write data.
- `address`  out  ADDR_W  memory address.
- `wr_en`  out  1  memory write enable.
- `data_out`  out  WORD_W  memory write data.
- `busy`  out  1  high in every state except IDLE.
- `active_stage`  out  clog2(NUM_STAGES)  index of the granted stage.
- `done`  out  1  one-cycle pulse when the run completes.
- `error`  out  1  sticky watchdog flag.

## Operation
- State register `state` and stage index `idx` are registered.
- **IDLE:**
  - `busy`=0.
  - If `en`=1, set `idx`=0, clear `error`, go to LAUNCH.
- **LAUNCH:**
  - `stage_start[idx]`=1 for this cycle only.
  - Clear the watchdog counter.
  - Go to WAIT.
- **WAIT:**
  - Memory port = stage `idx` signals (combinational mux on registered `idx`).
  - If `stage_done[idx]`=1, go to NEXT.
  - `stage_done` bits of non-granted stages are ignored.
- **NEXT:**
  - Bus turnaround cycle; `wr_en` is forced 0.
  - If `idx`==NUM_STAGES-1, go to FINISH; otherwise `idx`+1 and go to LAUNCH.
- **FINISH:** `done`=1 for one cycle, then go to IDLE.
- **Port gating:** outside WAIT, `address`=0, `data_out`=0 and `wr_en`=0. A stage can never write unless it is granted.
- **Abort:**
  - `abort`=1 in any non-IDLE state: next state is IDLE and `done` is not pulsed.
  - `wr_en` is forced 0 combinationally in that same cycle.
  - `abort` in IDLE is ignored.
- **Simultaneous abort and done:** abort wins.
- **Reset values:**
  - `state`=IDLE, `idx`=0, `error`=0.
  - `stage_start`=0, `done`=0, `busy`=0, `wr_en`=0, `address`=0, `data_out`=0, `active_stage`=0.
- **Mid-run reset:** asynchronous assertion of `nrst` returns everything to the reset values immediately. No partial-run state is retained.

## Timing
- `en` sampled at edge T0 → `stage_start[0]` high during cycle T0..T1.
- **Per stage:** 1 LAUNCH cycle + N WAIT cycles (until `stage_done` is seen) + 1 NEXT cycle.
- **Run latency:** sum of per-stage costs + 1 FINISH cycle. Example: 4 stages, each done after 1 WAIT cycle → `done` pulses 13 cycles after `en` is sampled.
- Next run can start the cycle after the `done` pulse (IDLE samples `en` again). `en` held high therefore re-runs back-to-back.
- `stage_done` must be registered by the stage. The sequencer samples it on the edge ending the WAIT cycle.

## Configuration
- **`SEQ_TIMEOUT_EN` defined:**
  - A watchdog counter increments every WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `stage_done[idx]`: `error` is set to 1 (sticky until the next accepted `en`), the state goes to IDLE, and no `done` pulse is produced.
- **`SEQ_TIMEOUT_EN` not defined:**
  - No counter is built; WAIT waits indefinitely.
  - `error` is tied to 0.

## Test plan
- **Reset:** `nrst`=0 mid-WAIT of stage 2 → all outputs 0 asynchronously; `state`=IDLE after release.
- **Normal run:** 4 stages, each asserts done one cycle after start → start pulses on stage 0,1,2,3 in order; `done` 13 cycles after `en`; `busy` high throughout.
- **Port isolation:** stage 1 drives `wr_en`=1, `address`=11'h274, data 16'hBEEF while stage 0 is granted → memory `wr_en`=0. When stage 1 is granted in WAIT, `address`=11'h274, `data_out`=16'hBEEF, `wr_en`=1. In the NEXT cycle `wr_en`=0.
- **Stray done:** `stage_done[3]`=1 while stage 1 is active → ignored; order unchanged.
- **Abort:** `abort` during stage 2 WAIT with stage `wr_en`=1 → `wr_en`=0 in the same cycle; IDLE next cycle; no `done`. Simultaneous `abort` and `stage_done` → same result.
- **Timeout (`SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):** stage 1 never completes → `error`=1 after 16 WAIT cycles, IDLE, no `done`. Next `en` clears `error`.
